// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing the single port of the data
// memory between NUM_REQ requesters (index 0 = CPU core), with read-data return
// routed to the requester that issued the read.
//
// Optional feature macro: MEM_ARB_LOCK_EN
//   defined   -> bus lock: ARB/LOCKED FSM, owner and lock_cnt implemented
//   undefined -> pure round-robin; lock port and LOCK_MAX are ignored
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req/we/lock       per-requester request, write enable, lock request
//   addr/wdata        flat buses, requester i at [i*W +: W]
//   gnt               one-hot combinational grant (access accepted this cycle)
//   rvalid/rdata      registered read return, rdata qualified by rvalid
//   mem_en/mem_we/mem_addr/mem_wdata  memory port (combinational from grant)
//   mem_rdata         memory read data, one cycle after a read
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  logic               rr_found;
  logic [PTR_W-1:0]   rr_idx;
  logic               grant_any;
  logic [PTR_W-1:0]   win_idx;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] k);
    if (32'(k) >= NUM_REQ - 1) return '0;
    return k + PTR_W'(1);
  endfunction

  // First requesting index at or after ptr, with wrap-around
  always_comb begin
    int unsigned idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    idx      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_idx   = PTR_W'(idx);
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_hold;
  logic             cnt_last;

  // The lock is only honoured while the owner keeps lock high; dropping it
  // releases the bus in the same cycle so others can win immediately.
  always_comb begin
    lock_hold = (state_q == LOCKED) && lock[owner_q];
    cnt_last  = (32'(lock_cnt_q) + 1) >= LOCK_MAX;
    if (lock_hold) begin
      grant_any = req[owner_q];
      win_idx   = owner_q;
    end else begin
      grant_any = rr_found;
      win_idx   = rr_idx;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      ptr_q      <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      ptr_q      <= ptr_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    ptr_d      = ptr_q;
    if (lock_hold) begin
      // Owner grants do not move ptr until the forced release
      if (grant_any) begin
        if (cnt_last) begin
          state_d    = ARB;
          lock_cnt_d = '0;
          ptr_d      = next_idx(owner_q);
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
    end else begin
      if (state_q == LOCKED) begin
        state_d    = ARB;
        lock_cnt_d = '0;
        ptr_d      = next_idx(owner_q);
      end
      if (grant_any) begin
        ptr_d = next_idx(win_idx);
        if (lock[win_idx] && LOCK_MAX > 1) begin
          state_d    = LOCKED;
          owner_d    = win_idx;
          lock_cnt_d = CNT_W'(1);
        end
      end
    end
  end
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{lock, 32'(LOCK_MAX)};

  always_comb begin
    grant_any = rr_found;
    win_idx   = rr_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) ptr_d = next_idx(win_idx);
  end
`endif

  // Grant decode and memory port mux; everything forced to 0 during reset
  always_comb begin
    gnt       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_any && !reset) begin
      gnt[win_idx] = 1'b1;
      mem_en       = 1'b1;
      mem_we       = we[win_idx];
      mem_addr     = addr[32'(win_idx)*ADDR_W +: ADDR_W];
      mem_wdata    = wdata[32'(win_idx)*DATA_W +: DATA_W];
    end
  end

  // A granted read returns exactly one cycle later to the same requester
  always_comb begin
    rvalid_d = gnt & ~we;
  end

  // Memory output is already registered; gate it so rdata is 0 without rvalid
  assign rvalid = rvalid_q;
  assign rdata  = (|rvalid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, we, lock;
  logic [14:0] addr;
  logic [29:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [9:0]  rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [9:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(10), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous 32 x 10 memory; contents mem[i] = i*17, except mem[5] = 'h2A
  logic [9:0] mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 10'(i * 17);
      mem[5] <= 10'h2A;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic [2:0] gnt;
    logic       en;
    logic       we;
    logic [4:0] addr;
    logic [9:0] wdata;
    logic [2:0] rv;
    logic [9:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compares the DUT against the expectation queued for this cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",       int'(gnt),       int'(e.gnt));
      chk("mem_en",    int'(mem_en),    int'(e.en));
      chk("mem_we",    int'(mem_we),    int'(e.we));
      chk("mem_addr",  int'(mem_addr),  int'(e.addr));
      chk("mem_wdata", int'(mem_wdata), int'(e.wdata));
      chk("rvalid",    int'(rvalid),    int'(e.rv));
      chk("rdata",     int'(rdata),     int'(e.rd));
    end
  end

  // Driver: apply one cycle of stimulus and queue the hand-computed response
  task automatic cyc(input logic r, input logic [2:0] rq, input logic [2:0] w,
                     input logic [2:0] lk, input logic [14:0] a, input logic [29:0] d,
                     input logic [2:0] eg, input logic [2:0] er, input logic [9:0] erd);
    exp_t e;
    int   k;
    @(posedge clk);
    #1;
    reset = r; req = rq; we = w; lock = lk; addr = a; wdata = d;
    k = 0;
    for (int i = 0; i < 3; i++) if (eg[i]) k = i;
    e.gnt   = eg;
    e.en    = |eg;
    e.we    = (|eg) ? w[k] : 1'b0;
    e.addr  = (|eg) ? a[k*5 +: 5] : 5'd0;
    e.wdata = (|eg) ? d[k*10 +: 10] : 10'd0;
    e.rv    = er;
    e.rd    = erd;
    exp_q.push_back(e);
  endtask

`ifdef MEM_ARB_LOCK_EN
  localparam logic [2:0] LK_T = 3'b000;
`else
  localparam logic [2:0] LK_T = 3'b001;
`endif

  localparam logic [14:0] A321  = {5'd3, 5'd2, 5'd1};
  localparam logic [14:0] A005  = {5'd0, 5'd0, 5'd5};
  localparam logic [14:0] A406  = {5'd4, 5'd0, 5'd6};
  localparam logic [14:0] A0310 = {5'd0, 5'd31, 5'd0};
  localparam logic [29:0] D155  = {10'h0, 10'h155, 10'h0};

  initial begin
    reset = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    // reset holds gnt and the memory port at 0 even with requests
    cyc(1, 3'b111, 3'b000, 3'b000, A321, 30'd0, 3'b000, 3'b000, 10'h000);
    cyc(1, 3'b111, 3'b000, 3'b000, A321, 30'd0, 3'b000, 3'b000, 10'h000);
    // single CPU read of mem[5]
    cyc(0, 3'b001, 3'b000, 3'b000, A005, 30'd0, 3'b001, 3'b000, 10'h000);
    // continuous 3-way reads rotate; data returns without bubbles
    cyc(0, 3'b111, 3'b000, 3'b000, A321, 30'd0, 3'b010, 3'b001, 10'h02A);
    cyc(0, 3'b111, 3'b000, 3'b000, A321, 30'd0, 3'b100, 3'b010, 10'd34);
    cyc(0, 3'b111, 3'b000, 3'b000, A321, 30'd0, 3'b001, 3'b100, 10'd51);
    cyc(0, 3'b111, 3'b000, 3'b000, A321, 30'd0, 3'b010, 3'b001, 10'd17);
    cyc(0, 3'b111, 3'b000, 3'b000, A321, 30'd0, 3'b100, 3'b010, 10'd34);
    // requester 1 writes 'h155 to addr 31 then reads it back
    cyc(0, 3'b010, 3'b010, 3'b000, A0310, D155, 3'b010, 3'b100, 10'd51);
    cyc(0, 3'b010, 3'b000, 3'b000, A0310, 30'd0, 3'b010, 3'b000, 10'h000);
    cyc(0, 3'b000, 3'b000, 3'b000, A0310, 30'd0, 3'b000, 3'b010, 10'h155);
    // pointer search with wrap-around: ptr=2, then 0, then 1
    cyc(0, 3'b101, 3'b000, 3'b000, A406, 30'd0, 3'b100, 3'b000, 10'h000);
    cyc(0, 3'b001, 3'b000, 3'b000, A406, 30'd0, 3'b001, 3'b100, 10'd68);
    cyc(0, 3'b101, 3'b000, 3'b000, A406, 30'd0, 3'b100, 3'b001, 10'd102);
    // reset in the cycle after a granted read drops the return
    cyc(0, 3'b001, 3'b000, 3'b000, A005, 30'd0, 3'b001, 3'b100, 10'd68);
    cyc(1, 3'b000, 3'b000, 3'b000, A005, 30'd0, 3'b000, 3'b000, 10'h000);
    // after reset ptr=0; lock[0] high is ignored without the lock feature
    cyc(0, 3'b111, 3'b000, LK_T, A321, 30'd0, 3'b001, 3'b000, 10'h000);
    cyc(0, 3'b111, 3'b000, LK_T, A321, 30'd0, 3'b010, 3'b001, 10'd17);
    cyc(0, 3'b111, 3'b000, LK_T, A321, 30'd0, 3'b100, 3'b010, 10'd34);
    cyc(0, 3'b111, 3'b000, LK_T, A321, 30'd0, 3'b001, 3'b100, 10'd51);
    cyc(0, 3'b000, 3'b000, 3'b000, A321, 30'd0, 3'b000, 3'b001, 10'd17);
`ifdef MEM_ARB_LOCK_EN
    // locked CPU takes 8 grants, forced release lets requester 2 in
    cyc(1, 3'b000, 3'b000, 3'b000, A321, 30'd0, 3'b000, 3'b000, 10'h000);
    cyc(0, 3'b101, 3'b000, 3'b001, {5'd3, 5'd0, 5'd5}, 30'd0, 3'b001, 3'b000, 10'h000);
    for (int i = 0; i < 7; i++)
      cyc(0, 3'b101, 3'b000, 3'b001, {5'd3, 5'd0, 5'd5}, 30'd0, 3'b001, 3'b001, 10'h02A);
    cyc(0, 3'b101, 3'b000, 3'b001, {5'd3, 5'd0, 5'd5}, 30'd0, 3'b100, 3'b001, 10'h02A);
    // relock, then dropping lock after 3 grants releases on the 4th cycle
    cyc(0, 3'b101, 3'b000, 3'b001, {5'd3, 5'd0, 5'd5}, 30'd0, 3'b001, 3'b100, 10'd51);
    cyc(0, 3'b101, 3'b000, 3'b001, {5'd3, 5'd0, 5'd5}, 30'd0, 3'b001, 3'b001, 10'h02A);
    cyc(0, 3'b101, 3'b000, 3'b001, {5'd3, 5'd0, 5'd5}, 30'd0, 3'b001, 3'b001, 10'h02A);
    cyc(0, 3'b101, 3'b000, 3'b000, {5'd3, 5'd0, 5'd5}, 30'd0, 3'b100, 3'b001, 10'h02A);
    cyc(0, 3'b000, 3'b000, 3'b000, {5'd3, 5'd0, 5'd5}, 30'd0, 3'b000, 3'b100, 10'd51);
`endif
    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
